// File: rtl/hazard_unit_n_pkg.sv
// ----------------------------------------------------------------------------
// hazard_unit_n_pkg
// Shared types and helpers for the decode-stage RAW hazard unit.
//   src_en_t    : which architectural source an operand reads (GPR / HI / LO)
//   gpr_ctrl_t  : decode operand request (rs, rt, rs_en, rt_en)
//   wb_ctrl_t   : write intent of one in-flight producer stage
//   md_state_t  : mult/div sequencer state (exported for debug)
//   X0          : hard-wired zero register, never forwarded
//   fwd_md()    : forward-select code of the MD result bus (FWD_DEPTH+1)
//   fwd_sel_w() : width of a forward-select code
// ----------------------------------------------------------------------------
package hazard_unit_n_pkg;

    localparam logic [4:0] X0 = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        GPR_EN   = 2'd1,
        HI_EN    = 2'd2,
        LO_EN    = 2'd3
    } src_en_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        src_en_t    rs_en;
        src_en_t    rt_en;
    } gpr_ctrl_t;

    typedef struct packed {
        logic       wr_en;
        logic [4:0] wr_gpr;
        logic       wr_hi;
        logic       wr_lo;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Codes: 0 = register file, k+1 = producer stage k, depth+1 = MD bus.
    function automatic int fwd_md(input int depth);
        return depth + 1;
    endfunction

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 2);
    endfunction

    function automatic logic is_hilo(input src_en_t en);
        return (en == HI_EN) || (en == LO_EN);
    endfunction

endpackage

// File: rtl/hazard_unit_n_if.sv
// ----------------------------------------------------------------------------
// hazard_unit_n_if
// Bundle between the decode stage (master) and the hazard unit (slave).
//   master -> slave : id_valid, gpr_ctrl, wb_ctrl_stg, stg_valid, stg_rdy,
//                     md_issue, md_is_div, md_abort
//   slave -> master : rs_fwd, rt_fwd, stall, md_busy, md_done, stall_cnt,
//                     md_state (debug view of the MD sequencer)
//
// Handshake: decode offers an instruction with id_valid (valid); the unit
// answers with ~stall (ready). An instruction, and its MD issue if md_issue
// is set, leaves decode only in a cycle where id_valid=1 and stall=0. Inputs
// must stay stable while stall is high.
// ----------------------------------------------------------------------------
interface hazard_unit_n_if #(
    parameter int FWD_DEPTH = 3,
    parameter int CNT_W     = 32
);
    import hazard_unit_n_pkg::*;

    localparam int FWD_SEL_W = fwd_sel_w(FWD_DEPTH);

    logic                            id_valid;
    gpr_ctrl_t                       gpr_ctrl;
    wb_ctrl_t [FWD_DEPTH-1:0]        wb_ctrl_stg;
    logic     [FWD_DEPTH-1:0]        stg_valid;
    logic     [FWD_DEPTH-1:0]        stg_rdy;
    logic                            md_issue;
    logic                            md_is_div;
    logic                            md_abort;

    logic     [FWD_SEL_W-1:0]        rs_fwd;
    logic     [FWD_SEL_W-1:0]        rt_fwd;
    logic                            stall;
    logic                            md_busy;
    logic                            md_done;
    logic     [CNT_W-1:0]            stall_cnt;
    md_state_t                       md_state;

    modport master (
        output id_valid, gpr_ctrl, wb_ctrl_stg, stg_valid, stg_rdy,
               md_issue, md_is_div, md_abort,
        input  rs_fwd, rt_fwd, stall, md_busy, md_done, stall_cnt, md_state
    );

    modport slave (
        input  id_valid, gpr_ctrl, wb_ctrl_stg, stg_valid, stg_rdy,
               md_issue, md_is_div, md_abort,
        output rs_fwd, rt_fwd, stall, md_busy, md_done, stall_cnt, md_state
    );

endinterface

// File: rtl/hazard_unit_n_fwd_match.sv
// ----------------------------------------------------------------------------
// hazard_unit_n_fwd_match
// Combinational producer scan for one decode operand.
//   reg_idx, reg_en         : operand register and which source it reads
//   wb_ctrl_stg, stg_valid  : write intent / liveness of each producer stage
//   stg_rdy                 : stage result already computed
//   hit                     : some live stage writes this operand
//   sel                     : k+1 of the youngest matching stage k (0 if none)
//   rdy                     : stg_rdy of that youngest matching stage
// ----------------------------------------------------------------------------
module hazard_unit_n_fwd_match
    import hazard_unit_n_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int FWD_SEL_W = 3
) (
    input  logic     [4:0]           reg_idx,
    input  src_en_t                  reg_en,
    input  wb_ctrl_t [FWD_DEPTH-1:0] wb_ctrl_stg,
    input  logic     [FWD_DEPTH-1:0] stg_valid,
    input  logic     [FWD_DEPTH-1:0] stg_rdy,
    output logic                     hit,
    output logic     [FWD_SEL_W-1:0] sel,
    output logic                     rdy
);

    logic [FWD_DEPTH-1:0] match;

    always_comb begin
        match = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (stg_valid[k]) begin
                case (reg_en)
                    GPR_EN:  match[k] = wb_ctrl_stg[k].wr_en &&
                                        (wb_ctrl_stg[k].wr_gpr == reg_idx) &&
                                        (reg_idx != X0);
                    HI_EN:   match[k] = wb_ctrl_stg[k].wr_hi;
                    LO_EN:   match[k] = wb_ctrl_stg[k].wr_lo;
                    default: match[k] = 1'b0;
                endcase
            end
        end
    end

    // Scan oldest to youngest so the youngest match overwrites the rest;
    // an unready youngest producer is reported as-is, never skipped.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        rdy = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit = 1'b1;
                sel = FWD_SEL_W'(k + 1);
                rdy = stg_rdy[k];
            end
        end
    end

endmodule

// File: rtl/hazard_unit_n.sv
// ----------------------------------------------------------------------------
// hazard_unit_n
// Decode-stage RAW hazard unit: per-operand forward selects, load-use stall,
// mult/div busy sequencer with HI/LO interlock, saturating stall counter.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : hazard_unit_n_if.slave (see interface for the signal list)
// ----------------------------------------------------------------------------
module hazard_unit_n
    import hazard_unit_n_pkg::*;
#(
    parameter int FWD_DEPTH = 3,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32,
    parameter int CNT_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_n_if.slave bus
);

    localparam int                   FWD_SEL_W  = fwd_sel_w(FWD_DEPTH);
    localparam logic [FWD_SEL_W-1:0] FWD_MD     = FWD_SEL_W'(fwd_md(FWD_DEPTH));
    localparam int                   MD_MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int                   MD_CNT_W   = $clog2(MD_MAX_LAT + 1);
    localparam logic [MD_CNT_W-1:0]  MUL_LOAD   = MD_CNT_W'(MUL_LAT - 1);
    localparam logic [MD_CNT_W-1:0]  DIV_LOAD   = MD_CNT_W'(DIV_LAT - 1);

    md_state_t             md_state;
    logic [MD_CNT_W-1:0]   md_cnt;
    logic                  md_done_q;
    logic [CNT_W-1:0]      stall_cnt_q;

    logic                  rs_hit, rt_hit, rs_rdy, rt_rdy;
    logic [FWD_SEL_W-1:0]  rs_sel, rt_sel;
    logic [FWD_SEL_W-1:0]  rs_fwd_c, rt_fwd_c;
    logic                  rs_hilo, rt_hilo;
    logic                  load_use, md_lock, stall_c, md_go;

    hazard_unit_n_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .FWD_SEL_W(FWD_SEL_W)) u_rs_match (
        .reg_idx     (bus.gpr_ctrl.rs),
        .reg_en      (bus.gpr_ctrl.rs_en),
        .wb_ctrl_stg (bus.wb_ctrl_stg),
        .stg_valid   (bus.stg_valid),
        .stg_rdy     (bus.stg_rdy),
        .hit         (rs_hit),
        .sel         (rs_sel),
        .rdy         (rs_rdy)
    );

    hazard_unit_n_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .FWD_SEL_W(FWD_SEL_W)) u_rt_match (
        .reg_idx     (bus.gpr_ctrl.rt),
        .reg_en      (bus.gpr_ctrl.rt_en),
        .wb_ctrl_stg (bus.wb_ctrl_stg),
        .stg_valid   (bus.stg_valid),
        .stg_rdy     (bus.stg_rdy),
        .hit         (rt_hit),
        .sel         (rt_sel),
        .rdy         (rt_rdy)
    );

    assign rs_hilo  = is_hilo(bus.gpr_ctrl.rs_en);
    assign rt_hilo  = is_hilo(bus.gpr_ctrl.rt_en);
    assign load_use = (rs_hit && !rs_rdy) || (rt_hit && !rt_rdy);
    // While an MD op is running, HI/LO are stale and the unit cannot take
    // another op; in MD_DONE the result is on the MD bus, so no interlock.
    assign md_lock  = (md_state == MD_RUN) && (rs_hilo || rt_hilo || bus.md_issue);
    assign stall_c  = bus.id_valid && (load_use || md_lock);
    assign md_go    = bus.id_valid && bus.md_issue && !stall_c;

    // A matching pipeline stage is younger than the HI/LO write landing this
    // cycle, so it takes precedence over the MD bus.
    always_comb begin
        rs_fwd_c = '0;
        rt_fwd_c = '0;
        if (bus.id_valid) begin
            if (rs_hit)
                rs_fwd_c = rs_sel;
            else if ((md_state == MD_DONE) && rs_hilo)
                rs_fwd_c = FWD_MD;
            if (rt_hit)
                rt_fwd_c = rt_sel;
            else if ((md_state == MD_DONE) && rt_hilo)
                rt_fwd_c = FWD_MD;
        end
    end

    // MD sequencer. md_cnt is loaded with LAT-1 on issue and the RUN->DONE
    // move happens on the cycle it steps to zero, so md_done lands exactly
    // LAT cycles after the issue cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_state  <= MD_IDLE;
            md_cnt    <= '0;
            md_done_q <= 1'b0;
        end else if (bus.md_abort) begin
            md_state  <= MD_IDLE;
            md_cnt    <= '0;
            md_done_q <= 1'b0;
        end else begin
            md_done_q <= 1'b0;
            case (md_state)
                MD_IDLE, MD_DONE: begin
                    if (md_go) begin
                        md_state <= MD_RUN;
                        md_cnt   <= bus.md_is_div ? DIV_LOAD : MUL_LOAD;
                    end else begin
                        md_state <= MD_IDLE;
                    end
                end
                MD_RUN: begin
                    if (md_cnt <= MD_CNT_W'(1)) begin
                        md_state  <= MD_DONE;
                        md_cnt    <= '0;
                        md_done_q <= 1'b1;
                    end else begin
                        md_cnt <= md_cnt - MD_CNT_W'(1);
                    end
                end
                default: md_state <= MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (stall_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign bus.rs_fwd    = rs_fwd_c;
    assign bus.rt_fwd    = rt_fwd_c;
    assign bus.stall     = stall_c;
    assign bus.md_busy   = (md_state != MD_IDLE);
    assign bus.md_done   = md_done_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.md_state  = md_state;

endmodule
